// File: rtl/karatsuba_mult_seq.sv
// -----------------------------------------------------------------------------
// karatsuba_mult_seq
//
// Sequential WIDTH x WIDTH Karatsuba multiplier. A single (H+1)x(H+1)
// multiplier (H = WIDTH/2) is time-shared across the three partial products
// Xh*Yh, Xl*Yl and (Xh+Xl)*(Yh+Yl). The partial products are then combined
// over a few cycles into the full 2*WIDTH product. With SIGNED=1 the operands
// are treated as two's complement: magnitudes are multiplied and the sign is
// applied to the result in the final step.
//
// Parameters
//   WIDTH   operand width in bits (even, >= 4)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands and result
//
// Ports
//   clk      rising-edge clock
//   RESET_N  asynchronous active-low reset
//   start    level request, only looked at while idle
//   X, Y     operands, captured on the accepting edge only
//   P        product register, holds until the next completion
//   BUSY     high whenever the unit is not idle
//   DONE     one-cycle pulse coincident with a fresh P
// -----------------------------------------------------------------------------
module karatsuba_mult_seq #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic [2*WIDTH-1:0] P,
  output logic               BUSY,
  output logic               DONE
);

  localparam int H = WIDTH / 2;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD       = 4'd1,
    MUL_A      = 4'd2,
    MUL_B      = 4'd3,
    MUL_DE     = 4'd4,
    SOMA_AB    = 4'd5,
    SUB_DE_AB  = 4'd6,
    SOMA_FINAL = 4'd7,
    FIM        = 4'd8
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic               neg_q;
  logic [H:0]         sx_q;
  logic [H:0]         sy_q;
  logic [2*H-1:0]     a_q;
  logic [2*H-1:0]     b_q;
  logic [2*H+1:0]     de_q;
  logic [2*H:0]       ab_q;
  logic [2*H+1:0]     m_q;
  logic [2*WIDTH-1:0] p_q;

  // Operand conditioning at capture: magnitudes plus the result sign.
  // The magnitude of the most negative value is 2^(WIDTH-1), which still
  // fits the unsigned WIDTH-bit register, so plain negation is enough.
  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic             neg_in;

  generate
    if (SIGNED != 0) begin : g_signed
      assign x_abs  = X[WIDTH-1] ? -X : X;
      assign y_abs  = Y[WIDTH-1] ? -Y : Y;
      assign neg_in = X[WIDTH-1] ^ Y[WIDTH-1];
    end else begin : g_unsigned
      assign x_abs  = X;
      assign y_abs  = Y;
      assign neg_in = 1'b0;
    end
  endgenerate

  // Shared multiplier; the operand pair is chosen by the current state.
  logic [H:0]     mul_a;
  logic [H:0]     mul_b;
  logic [2*H+1:0] prod;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_A: begin
        mul_a = {1'b0, x_q[WIDTH-1:H]};
        mul_b = {1'b0, y_q[WIDTH-1:H]};
      end
      MUL_B: begin
        mul_a = {1'b0, x_q[H-1:0]};
        mul_b = {1'b0, y_q[H-1:0]};
      end
      MUL_DE: begin
        mul_a = sx_q;
        mul_b = sy_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign prod = {{(H+1){1'b0}}, mul_a} * {{(H+1){1'b0}}, mul_b};

  // Final recombination. Since B < 2^(2H), (A << 2H) + B is just the
  // concatenation {A, B}; only the middle term needs a real adder.
  // M never exceeds 2H+1 significant bits, so bits shifted out are zero.
  logic [2*WIDTH-1:0] r_sum;
  assign r_sum = {a_q, b_q} + ((2*WIDTH)'(m_q) << H);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      neg_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      de_q    <= '0;
      ab_q    <= '0;
      m_q     <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x_abs;
            y_q     <= y_abs;
            neg_q   <= neg_in;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          sx_q    <= {1'b0, x_q[WIDTH-1:H]} + {1'b0, x_q[H-1:0]};
          sy_q    <= {1'b0, y_q[WIDTH-1:H]} + {1'b0, y_q[H-1:0]};
          state_q <= MUL_A;
        end
        MUL_A: begin
          a_q     <= prod[2*H-1:0];
          state_q <= MUL_B;
        end
        MUL_B: begin
          b_q     <= prod[2*H-1:0];
          state_q <= MUL_DE;
        end
        MUL_DE: begin
          de_q    <= prod;
          state_q <= SOMA_AB;
        end
        SOMA_AB: begin
          ab_q    <= {1'b0, a_q} + {1'b0, b_q};
          state_q <= SUB_DE_AB;
        end
        SUB_DE_AB: begin
          // DE >= A + B always, so this difference is never negative.
          m_q     <= de_q - {1'b0, ab_q};
          state_q <= SOMA_FINAL;
        end
        SOMA_FINAL: begin
          p_q     <= neg_q ? -r_sum : r_sum;
          state_q <= FIM;
        end
        FIM: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign P    = p_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == FIM);

endmodule
